// File: rtl/cpu_sequencer.sv
// Fetch/execute controller for the 8-bit accumulator CPU: latches instructions, gates decoder
// strobes to one cycle per instruction, stalls on data memory and provides run/step/halt control.
module cpu_sequencer #(
  parameter int unsigned INSTR_WIDTH = 16,
  parameter int unsigned CNT_WIDTH   = 16,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic                   step,
  input  logic                   halt_req,
  input  logic [INSTR_WIDTH-1:0] instruction,
  output logic [INSTR_WIDTH-1:0] instr_q,
  input  logic                   id_RF_we,
  input  logic                   id_A_we,
  input  logic                   id_MEM_we,
  input  logic                   id_PC_jump_enable,
  input  logic                   mem_ready,
  output logic                   ir_we,
  output logic                   RF_we,
  output logic                   A_we,
  output logic                   MEM_we,
  output logic                   PC_jump_enable,
  output logic                   pc_advance,
  output logic                   halted,
  output logic                   halt_hit,
  output logic [CNT_WIDTH-1:0]   instr_count
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StExecute,
    StWaitMem,
    StRetire
  } state_e;

  state_e                 state_q, state_d;
  logic [INSTR_WIDTH-1:0] instr_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;
  logic                   halt_hit_q, halt_hit_d;
  logic                   halt_pend_q, halt_pend_d;
  logic                   single_q, single_d;
  logic                   ir_we_c, strobe_en, pc_adv_c;
  logic [3:0]             opcode;

  assign opcode = instr_q[INSTR_WIDTH-1 -: 4];

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    count_d     = count_q;
    halt_hit_d  = halt_hit_q;
    halt_pend_d = halt_pend_q;
    single_d    = single_q;
    ir_we_c     = 1'b0;
    strobe_en   = 1'b0;
    pc_adv_c    = 1'b0;

    if (state_q != StIdle && halt_req) begin
      halt_pend_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        // A halt request arriving together with step/run takes priority.
        if (!halt_req) begin
          if (step) begin
            state_d    = StFetch;
            single_d   = 1'b1;
            halt_hit_d = 1'b0;
          end else if (run && !halt_hit_q) begin
            state_d  = StFetch;
            single_d = 1'b0;
          end
        end
      end
      StFetch: begin
        ir_we_c = 1'b1;
        instr_d = instruction;
        state_d = StExecute;
      end
      StExecute: begin
        if (opcode == HALT_OPCODE) begin
          halt_hit_d = 1'b1;
          state_d    = StRetire;
        end else if (id_MEM_we && !mem_ready) begin
          state_d = StWaitMem;
        end else begin
          strobe_en = 1'b1;
          state_d   = StRetire;
        end
      end
      StWaitMem: begin
        if (mem_ready) begin
          strobe_en = 1'b1;
          state_d   = StRetire;
        end
      end
      StRetire: begin
        pc_adv_c    = 1'b1;
        count_d     = count_q + CNT_WIDTH'(1);
        halt_pend_d = 1'b0;
        single_d    = 1'b0;
        if (halt_pend_q || halt_req || single_q || !run || halt_hit_q) begin
          state_d = StIdle;
        end else begin
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      instr_q     <= '0;
      count_q     <= '0;
      halt_hit_q  <= 1'b0;
      halt_pend_q <= 1'b0;
      single_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      count_q     <= count_d;
      halt_hit_q  <= halt_hit_d;
      halt_pend_q <= halt_pend_d;
      single_q    <= single_d;
    end
  end

  // Reset aborts the instruction in flight, so no strobe may escape on the reset edge.
  assign ir_we          = ir_we_c & ~rst;
  assign RF_we          = strobe_en & id_RF_we & ~rst;
  assign A_we           = strobe_en & id_A_we & ~rst;
  assign MEM_we         = strobe_en & id_MEM_we & ~rst;
  assign pc_advance     = pc_adv_c & ~rst;
  assign PC_jump_enable = pc_advance & id_PC_jump_enable;
  assign halted         = (state_q == StIdle);
  assign halt_hit       = halt_hit_q;
  assign instr_count    = count_q;

endmodule
